tlp_ocp_bridge: RTL and testbench
=================================

# tlp_ocp_bridge

Parametrised PCIe-TLP-to-OCP 2.2 master bridge: consumes memory read/write TLPs one DW per beat from the AXI4-Stream RX FIFO and issues single-request OCP bursts (command phase plus handshaked write data). It supports 3DW and 4DW headers, configurable address width, OCP backpressure, byte enables and tlast/length error recovery.

## Interface
- ADDR_W, 64, OCP address width; 32 or 64
- ERR_W, 8, width of saturating error counter
- clk  in  1  single clock for stream and OCP sides
- reset_n  in  1  asynchronous, active-low reset
- s_axis_tvalid / s_axis_tready  in/out  1  stream handshake from RX FIFO
- s_axis_tdata  in  32  one TLP DW per beat
- s_axis_tkeep  in  4  ignored except logged; all DWs treated full
- s_axis_tlast  in  1  last beat of TLP
- m_cmd  out  3  OCP MCmd: 0 IDLE, 1 WR, 2 RD
- m_cmd_accept  in  1  OCP SCmdAccept
- m_addr  out  ADDR_W  byte address, bits [1:0] = 0
- m_burst_length  out  10  DW count; 0 encodes 1024
- m_burst_seq  out  3  always 0 (INCR)
- m_burst_single_req  out  1  always 1 while m_cmd != IDLE
- m_data / m_byte_en  out  32 / 4  write data and byte enables
- m_data_valid / m_data_last  out  1 / 1  write data valid, last beat of burst
- m_data_accept  in  1  OCP SDataAccept
- drop_pulse  out  1  one-cycle pulse per dropped or malformed TLP
- err_count  out  ERR_W  saturating count of drop_pulse events

## Operation
- DW0: fmt = [31:29], type = [28:24], length = [9:0]. Supported: type 0, fmt 000/001 (MRd 3DW/4DW), 010/011 (MWr 3DW/4DW). Anything else -> DROP.
- DW1: first_be = [3:0], last_be = [7:4]. 3DW: DW2 = addr[31:2]. 4DW: DW2 = addr[63:32], DW3 = addr[31:2]. With ADDR_W=32, a 4DW TLP with nonzero DW2 -> DROP.
- States: HDR0, HDR1, HDR2, HDR3, RD_CMD, WR_CMD, WR_DATA, PAD, DROP.
- HDR*: s_axis_tready=1; HDR3 visited only for 4DW. tlast on a header beat before the final header DW, or tlast on the final header DW of a MWr -> drop_pulse, back to HDR0 (or DROP if tlast not yet seen). Missing tlast on the final header DW of a MRd -> DROP.
- RD_CMD/WR_CMD: m_cmd held with stable addr/length until m_cmd_accept; s_axis_tready=0.
- WR_DATA: s_axis_tready = !m_data_valid || m_data_accept. Byte enables: beat 1 = first_be, final beat = last_be, others 4'hF; length 1 uses first_be. Down-counter of remaining DWs (11 bits; 0 loads 1024).
- Early tlast (counter not at last beat) -> drop_pulse, enter PAD: emit remaining beats with m_byte_en=0, m_data=0, stream tready=0.
- Counter reaches last beat without tlast -> m_data_last still asserted on that beat, drop_pulse, DROP drains to tlast.
- DROP: tready=1, discard beats until tlast accepted, then HDR0.
- err_count saturates at all-ones; it never wraps.

## Timing
- Reset values: all outputs 0; m_burst_single_req 0; state HDR0; s_axis_tready 0 during reset, 1 the first cycle after release.
- m_cmd valid the cycle after the final header beat handshake; next TLP header accepted the cycle after m_cmd_accept (MRd) or after the m_data_last handshake (MWr).
- m_data registered: beat appears the cycle after its stream handshake; sustained 1 DW/cycle with m_data_accept held high.
- m_cmd_accept and m_data_accept are treated independently; no data is presented before the WR command is accepted.
- reset_n deasserted mid-burst: immediate return to reset values; the partial TLP is lost and is not counted.

## Structure
- Package tlp_ocp_pkg: fmt/type constants, MCmd encodings, state enum, HDR field bit positions.
- Sub-module tlp_hdr_decode: combinational DW0 classifier producing is_rd, is_wr, is_4dw, supported, length.

## Test plan
- 3DW MRd 0x00000004, DW1 0x0F, DW2 0x00001000 + tlast -> m_cmd=2, addr 0x1000, length 4; no data beats.
- 4DW MRd 0x20000000, 0, 0xeeeeeeee, 0xffffffff + tlast -> addr 0xeeeeeeee_fffffffc, length 0 (1024).
- 4DW MWr 0x6000000d, DW1 0xFF, 0xdddddddd, 0xcccccccc, 13 data DWs 0xffffffff..0x33333333 -> 13 beats, m_data_last on 0x33333333, byte_en all 0xF.
- Same MWr with m_data_accept toggled 1/0 and m_cmd_accept delayed 3 cycles -> no beat lost or duplicated; m_cmd stable until accept.
- MWr length 4 with tlast on data beat 2 -> 2 real beats, 2 pad beats with byte_en 0, drop_pulse, err_count 1.
- Type 0x0A (completion) TLP of 5 beats -> all drained, no m_cmd, drop_pulse; reset_n pulsed mid-MWr -> outputs zero and the next TLP decodes cleanly.

Source files
------------

// File: rtl/tlp_ocp_bridge_pkg.sv
// Shared constants for the TLP-to-OCP bridge: TLP header fields, OCP command
// encodings and the bridge FSM state type.
package tlp_ocp_pkg;

  localparam logic [2:0] FMT_MRD_3DW = 3'b000;
  localparam logic [2:0] FMT_MRD_4DW = 3'b001;
  localparam logic [2:0] FMT_MWR_3DW = 3'b010;
  localparam logic [2:0] FMT_MWR_4DW = 3'b011;
  localparam logic [4:0] TYPE_MEM    = 5'd0;

  localparam logic [2:0] MCMD_IDLE = 3'd0;
  localparam logic [2:0] MCMD_WR   = 3'd1;
  localparam logic [2:0] MCMD_RD   = 3'd2;

  localparam int FMT_MSB  = 31;
  localparam int FMT_LSB  = 29;
  localparam int TYPE_MSB = 28;
  localparam int TYPE_LSB = 24;
  localparam int LEN_MSB  = 9;
  localparam int LEN_LSB  = 0;
  localparam int FBE_MSB  = 3;
  localparam int FBE_LSB  = 0;
  localparam int LBE_MSB  = 7;
  localparam int LBE_LSB  = 4;

  typedef enum logic [3:0] {
    ST_HDR0, ST_HDR1, ST_HDR2, ST_HDR3,
    ST_RD_CMD, ST_WR_CMD, ST_WR_DATA, ST_PAD, ST_DROP
  } state_t;

  // A length field of zero means the maximum 1024-DW payload.
  function automatic logic [10:0] dw_count(input logic [9:0] len);
    return (len == 10'd0) ? 11'd1024 : {1'b0, len};
  endfunction

endpackage

// File: rtl/tlp_ocp_bridge_hdr_decode.sv
// Combinational classifier for TLP header DW0: memory read/write, header size
// and payload length.
module tlp_hdr_decode
  import tlp_ocp_pkg::*;
(
  input  logic [31:0] i_dw0,
  output logic        o_is_rd,
  output logic        o_is_wr,
  output logic        o_is_4dw,
  output logic        o_supported,
  output logic [9:0]  o_length
);

  logic [2:0] w_fmt;
  logic [4:0] w_type;
  logic       w_unused;

  assign w_fmt    = i_dw0[FMT_MSB:FMT_LSB];
  assign w_type   = i_dw0[TYPE_MSB:TYPE_LSB];
  assign o_length = i_dw0[LEN_MSB:LEN_LSB];
  assign w_unused = ^i_dw0[23:10];

  assign o_is_rd     = (w_type == TYPE_MEM) && (w_fmt == FMT_MRD_3DW || w_fmt == FMT_MRD_4DW);
  assign o_is_wr     = (w_type == TYPE_MEM) && (w_fmt == FMT_MWR_3DW || w_fmt == FMT_MWR_4DW);
  assign o_is_4dw    = w_fmt[0];
  assign o_supported = o_is_rd || o_is_wr;

endmodule

// File: rtl/tlp_ocp_bridge.sv
// PCIe memory-request TLP stream to OCP single-request burst master, with
// padding/draining recovery for TLPs whose tlast disagrees with their length.
module tlp_ocp_bridge
  import tlp_ocp_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [31:0]       s_axis_tdata,
  input  logic [3:0]        s_axis_tkeep,
  input  logic              s_axis_tlast,
  output logic [2:0]        m_cmd,
  input  logic              m_cmd_accept,
  output logic [ADDR_W-1:0] m_addr,
  output logic [9:0]        m_burst_length,
  output logic [2:0]        m_burst_seq,
  output logic              m_burst_single_req,
  output logic [31:0]       m_data,
  output logic [3:0]        m_byte_en,
  output logic              m_data_valid,
  output logic              m_data_last,
  input  logic              m_data_accept,
  output logic              drop_pulse,
  output logic [ERR_W-1:0]  err_count
);

  state_t             r_state, w_next, w_final_next;
  logic               r_ready_en, r_is_wr, r_is_4dw, r_first;
  logic [9:0]         r_len;
  logic [3:0]         r_first_be, r_last_be, r_be, w_ld_be;
  logic [31:0]        r_addr_hi, r_addr_lo, r_data, w_ld_data;
  logic [10:0]        r_rem;
  logic               r_dvalid, r_dlast, r_drop;
  logic [ERR_W-1:0]   r_err;
  logic               w_is_rd, w_is_wr, w_is_4dw, w_supported;
  logic [9:0]         w_len;
  logic               w_tready, w_hs, w_out_free, w_drop, w_load, w_ld_last, w_final_drop;
  logic [63:0]        w_addr64;
  logic               w_unused;

  tlp_hdr_decode u_hdr_decode (
    .i_dw0       (s_axis_tdata),
    .o_is_rd     (w_is_rd),
    .o_is_wr     (w_is_wr),
    .o_is_4dw    (w_is_4dw),
    .o_supported (w_supported),
    .o_length    (w_len)
  );

  assign w_hs       = s_axis_tvalid && w_tready;
  assign w_out_free = !r_dvalid || m_data_accept;

  // A MWr header must be followed by payload; a MRd header must end the TLP.
  assign w_final_next = r_is_wr ? (s_axis_tlast ? ST_HDR0 : ST_WR_CMD)
                                : (s_axis_tlast ? ST_RD_CMD : ST_DROP);
  assign w_final_drop = r_is_wr ? s_axis_tlast : !s_axis_tlast;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_HDR0;
      r_ready_en <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_ready_en <= 1'b1;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_tready  = 1'b0;
    w_drop    = 1'b0;
    w_load    = 1'b0;
    w_ld_data = '0;
    w_ld_be   = '0;
    w_ld_last = 1'b0;
    case (r_state)
      ST_HDR0: begin
        // Hold off a new header while the previous burst's last beat is pending.
        w_tready = r_ready_en && !r_dvalid;
        if (w_hs) begin
          if (s_axis_tlast) begin
            w_drop = 1'b1;
          end else if (!w_supported) begin
            w_drop = 1'b1;
            w_next = ST_DROP;
          end else begin
            w_next = ST_HDR1;
          end
        end
      end
      ST_HDR1: begin
        w_tready = !r_dvalid;
        if (w_hs) begin
          w_drop = s_axis_tlast;
          w_next = s_axis_tlast ? ST_HDR0 : ST_HDR2;
        end
      end
      ST_HDR2: begin
        w_tready = !r_dvalid;
        if (w_hs) begin
          if (!r_is_4dw) begin
            w_drop = w_final_drop;
            w_next = w_final_next;
          end else if (s_axis_tlast) begin
            w_drop = 1'b1;
            w_next = ST_HDR0;
          end else if (ADDR_W == 32 && s_axis_tdata != 32'd0) begin
            w_drop = 1'b1;
            w_next = ST_DROP;
          end else begin
            w_next = ST_HDR3;
          end
        end
      end
      ST_HDR3: begin
        w_tready = !r_dvalid;
        if (w_hs) begin
          w_drop = w_final_drop;
          w_next = w_final_next;
        end
      end
      ST_RD_CMD: if (m_cmd_accept) w_next = ST_HDR0;
      ST_WR_CMD: if (m_cmd_accept) w_next = ST_WR_DATA;
      ST_WR_DATA: begin
        w_tready = w_out_free;
        if (w_hs) begin
          w_load    = 1'b1;
          w_ld_data = s_axis_tdata;
          w_ld_last = (r_rem == 11'd1);
          w_ld_be   = r_first ? r_first_be : (w_ld_last ? r_last_be : 4'hF);
          if (w_ld_last) begin
            w_drop = !s_axis_tlast;
            w_next = s_axis_tlast ? ST_HDR0 : ST_DROP;
          end else if (s_axis_tlast) begin
            w_drop = 1'b1;
            w_next = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        if (w_out_free) begin
          w_load    = 1'b1;
          w_ld_last = (r_rem == 11'd1);
          if (w_ld_last) w_next = ST_HDR0;
        end
      end
      ST_DROP: begin
        w_tready = 1'b1;
        if (w_hs && s_axis_tlast) w_next = ST_HDR0;
      end
      default: w_next = ST_HDR0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_is_wr    <= 1'b0;
      r_is_4dw   <= 1'b0;
      r_len      <= '0;
      r_first_be <= '0;
      r_last_be  <= '0;
      r_addr_hi  <= '0;
      r_addr_lo  <= '0;
    end else if (w_hs) begin
      case (r_state)
        ST_HDR0: begin
          r_is_wr  <= w_is_wr;
          r_is_4dw <= w_is_4dw;
          r_len    <= w_len;
        end
        ST_HDR1: begin
          r_first_be <= s_axis_tdata[FBE_MSB:FBE_LSB];
          r_last_be  <= s_axis_tdata[LBE_MSB:LBE_LSB];
        end
        ST_HDR2: begin
          if (r_is_4dw) begin
            r_addr_hi <= s_axis_tdata;
          end else begin
            r_addr_hi <= '0;
            r_addr_lo <= {s_axis_tdata[31:2], 2'b00};
          end
        end
        ST_HDR3: r_addr_lo <= {s_axis_tdata[31:2], 2'b00};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rem   <= '0;
      r_first <= 1'b0;
    end else if (r_state == ST_WR_CMD && m_cmd_accept) begin
      r_rem   <= dw_count(r_len);
      r_first <= 1'b1;
    end else if (w_load) begin
      r_rem   <= r_rem - 11'd1;
      r_first <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data   <= '0;
      r_be     <= '0;
      r_dvalid <= 1'b0;
      r_dlast  <= 1'b0;
    end else if (w_load) begin
      r_data   <= w_ld_data;
      r_be     <= w_ld_be;
      r_dvalid <= 1'b1;
      r_dlast  <= w_ld_last;
    end else if (m_data_accept) begin
      r_data   <= '0;
      r_be     <= '0;
      r_dvalid <= 1'b0;
      r_dlast  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_drop <= 1'b0;
      r_err  <= '0;
    end else begin
      r_drop <= w_drop;
      if (w_drop && !(&r_err)) r_err <= r_err + 1'b1;
    end
  end

  assign w_addr64           = {r_addr_hi, r_addr_lo};
  assign w_unused           = ^{s_axis_tkeep, w_addr64, w_is_rd};
  assign s_axis_tready      = w_tready;
  assign m_cmd              = (r_state == ST_RD_CMD) ? MCMD_RD :
                              (r_state == ST_WR_CMD) ? MCMD_WR : MCMD_IDLE;
  assign m_addr             = w_addr64[ADDR_W-1:0];
  assign m_burst_length     = r_len;
  assign m_burst_seq        = 3'd0;
  assign m_burst_single_req = (m_cmd != MCMD_IDLE);
  assign m_data             = r_data;
  assign m_byte_en          = r_be;
  assign m_data_valid       = r_dvalid;
  assign m_data_last        = r_dlast;
  assign drop_pulse         = r_drop;
  assign err_count          = r_err;

endmodule

// File: tb/tb_tlp_ocp_bridge.sv
// Scoreboard bench for tlp_ocp_bridge: a TLP-level reference model queues the
// expected OCP commands, write beats and drop count; monitors pop and compare.
module tb_tlp_ocp_bridge;

  localparam int ADDR_W = 64;
  localparam int ERR_W  = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [31:0]       s_axis_tdata;
  logic [3:0]        s_axis_tkeep;
  logic [2:0]        m_cmd, m_burst_seq;
  logic              m_cmd_accept, m_burst_single_req;
  logic [ADDR_W-1:0] m_addr;
  logic [9:0]        m_burst_length;
  logic [31:0]       m_data;
  logic [3:0]        m_byte_en;
  logic              m_data_valid, m_data_last, m_data_accept, drop_pulse;
  logic [ERR_W-1:0]  err_count;

  tlp_ocp_bridge #(.ADDR_W(ADDR_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .m_cmd(m_cmd), .m_cmd_accept(m_cmd_accept), .m_addr(m_addr),
    .m_burst_length(m_burst_length), .m_burst_seq(m_burst_seq),
    .m_burst_single_req(m_burst_single_req),
    .m_data(m_data), .m_byte_en(m_byte_en), .m_data_valid(m_data_valid),
    .m_data_last(m_data_last), .m_data_accept(m_data_accept),
    .drop_pulse(drop_pulse), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  cmd;
    logic [63:0] addr;
    logic [9:0]  len;
  } cmd_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  be;
    logic        last;
  } beat_t;

  cmd_t  cmd_q[$];
  beat_t dat_q[$];
  int    checks = 0;
  int    errors = 0;
  int    exp_drops = 0;
  int    obs_drops = 0;
  bit    sb_on = 1'b1;
  int    dacc_mode = 0;
  int    cmd_delay = 0;
  int    gap_pct = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: expected OCP activity of one complete TLP (tlast on its final DW).
  task automatic model_tlp(input logic [31:0] b[$]);
    int          n, nh, L, nd;
    logic [2:0]  fmt;
    logic [4:0]  typ;
    logic [9:0]  len;
    logic [63:0] addr;
    logic [3:0]  fbe, lbe;
    n   = b.size();
    fmt = b[0][31:29];
    typ = b[0][28:24];
    len = b[0][9:0];
    nh  = fmt[0] ? 4 : 3;
    if (typ != 5'd0 || fmt > 3'd3 || n < nh) begin
      exp_drops++;
      return;
    end
    addr = fmt[0] ? {b[2], b[3][31:2], 2'b00} : {32'h0, b[2][31:2], 2'b00};
    fbe  = b[1][3:0];
    lbe  = b[1][7:4];
    if (!fmt[1]) begin
      if (n == nh) cmd_q.push_back('{3'd2, addr, len});
      else exp_drops++;
      return;
    end
    if (n == nh) begin
      exp_drops++;
      return;
    end
    cmd_q.push_back('{3'd1, addr, len});
    L  = (len == 10'd0) ? 1024 : int'(len);
    nd = n - nh;
    for (int i = 0; i < L; i++) begin
      if (i < nd) dat_q.push_back('{b[nh+i], (i == 0) ? fbe : ((i == L-1) ? lbe : 4'hF), i == L-1});
      else        dat_q.push_back('{32'h0, 4'h0, i == L-1});
    end
    if (nd != L) exp_drops++;
  endtask

  task automatic send_beat(input logic [31:0] dw, input logic last);
    int n;
    bit hs;
    n = 0;
    @(negedge clk);
    while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
      s_axis_tvalid = 1'b0;
      @(negedge clk);
    end
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = dw;
    s_axis_tlast  = last;
    s_axis_tkeep  = 4'hF;
    forever begin
      #1;
      hs = s_axis_tready;
      @(posedge clk);
      if (hs) break;
      n++;
      if (n > 3000) begin
        checks++;
        errors++;
        $display("FAIL stream_timeout beat=%0h tready stayed 0 for %0d cycles", dw, n);
        break;
      end
      @(negedge clk);
    end
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_tlp(input logic [31:0] b[$]);
    if (sb_on) model_tlp(b);
    for (int i = 0; i < b.size(); i++) send_beat(b[i], i == b.size() - 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((cmd_q.size() != 0 || dat_q.size() != 0) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 6000) begin
      errors++;
      $display("FAIL idle_timeout cmd_left=%0d data_left=%0d required=0", cmd_q.size(), dat_q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input logic exp_ready);
    check("rst_tready", s_axis_tready, exp_ready);
    check("rst_m_cmd", m_cmd, 0);
    check("rst_single_req", m_burst_single_req, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_length", m_burst_length, 0);
    check("rst_data_valid", m_data_valid, 0);
    check("rst_data", {m_data, m_byte_en, m_data_last}, 0);
    check("rst_drop_pulse", drop_pulse, 0);
    check("rst_err_count", err_count, 0);
  endtask

  // OCP slave: command accept after cmd_delay cycles, data accept per dacc_mode.
  initial begin
    int wc;
    bit tog;
    wc = 0;
    tog = 1'b0;
    m_cmd_accept  = 1'b0;
    m_data_accept = 1'b0;
    forever begin
      @(negedge clk);
      if (m_cmd != 3'd0) begin
        m_cmd_accept = (wc >= cmd_delay);
        wc++;
      end else begin
        m_cmd_accept = 1'b0;
        wc = 0;
      end
      case (dacc_mode)
        0: m_data_accept = 1'b1;
        1: begin tog = ~tog; m_data_accept = tog; end
        default: m_data_accept = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: every visible command is compared each cycle (stability), popped on accept.
  initial begin
    cmd_t  c;
    beat_t d;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n && sb_on) begin
        if (m_cmd != 3'd0) begin
          if (cmd_q.size() == 0) begin
            check("cmd_unexpected", m_cmd, 0);
          end else begin
            c = cmd_q[0];
            check("m_cmd", m_cmd, c.cmd);
            check("m_addr", m_addr, c.addr);
            check("m_burst_length", m_burst_length, c.len);
            check("m_burst_single_req", m_burst_single_req, 1);
            check("m_burst_seq", m_burst_seq, 0);
            if (m_cmd_accept) void'(cmd_q.pop_front());
          end
        end
        if (m_data_valid && m_data_accept) begin
          if (dat_q.size() == 0) begin
            check("data_unexpected", m_data_valid, 0);
          end else begin
            d = dat_q.pop_front();
            check("m_data", m_data, d.data);
            check("m_byte_en", m_byte_en, d.be);
            check("m_data_last", m_data_last, d.last);
          end
        end
        if (drop_pulse) obs_drops++;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] b[$];
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tkeep  = 4'h0;

    #12;
    check_reset_outputs(1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    check("tready_after_reset", s_axis_tready, 1);

    // 3DW MRd, length 4
    b = {32'h00000004, 32'h0000000F, 32'h00001000};
    send_tlp(b);
    wait_idle();
    // 4DW MRd, length 0 (1024 DW)
    b = {32'h20000000, 32'h00000000, 32'heeeeeeee, 32'hffffffff};
    send_tlp(b);
    wait_idle();
    // 4DW MWr, 13 DWs
    b = {32'h6000000d, 32'h000000FF, 32'hdddddddd, 32'hcccccccc};
    for (int i = 0; i < 13; i++) b.push_back(32'hffffffff - 32'h11111111 * i);
    send_tlp(b);
    wait_idle();
    // same MWr with toggling data accept and delayed command accept
    dacc_mode = 1;
    cmd_delay = 3;
    send_tlp(b);
    wait_idle();
    dacc_mode = 0;
    cmd_delay = 0;
    // MWr length 4 with tlast on data beat 2
    b = {32'h40000004, 32'h000000A5, 32'h00002000, 32'h11111111, 32'h22222222};
    send_tlp(b);
    wait_idle();
    // completion TLP of 5 beats
    b = {32'h4A000001, 32'h01020304, 32'h05060708, 32'h090a0b0c, 32'h0d0e0f10};
    send_tlp(b);
    wait_idle();
    check("err_count_directed", err_count, exp_drops);
    check("drop_pulses_directed", obs_drops, exp_drops);

    // reset mid-MWr: partial TLP is lost
    sb_on = 1'b0;
    b = {32'h40000008, 32'h000000FF, 32'h00003000, 32'haaaa0001, 32'haaaa0002, 32'haaaa0003};
    for (int i = 0; i < b.size(); i++) send_beat(b[i], 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_outputs(1'b0);
    repeat (3) @(negedge clk);
    cmd_q.delete();
    dat_q.delete();
    exp_drops = 0;
    obs_drops = 0;
    reset_n = 1'b1;
    sb_on = 1'b1;
    @(negedge clk);
    #1;
    check("tready_after_midreset", s_axis_tready, 1);
    b = {32'h00000002, 32'h000000F0, 32'h00004008};
    send_tlp(b);
    wait_idle();
    check("err_count_after_reset", err_count, 0);

    // randomized TLP mix
    for (int t = 0; t < 40; t++) begin
      int          kind, L, nh, total, sub;
      bit          four, is_wr;
      logic [2:0]  fmt;
      logic [4:0]  typ;
      kind  = $urandom_range(0, 9);
      four  = 1'($urandom_range(0, 1));
      nh    = four ? 4 : 3;
      L     = $urandom_range(1, 12);
      is_wr = (kind >= 3 && kind <= 6) || kind == 9 || (kind == 8 && $urandom_range(0, 1) == 1);
      fmt   = {1'b0, is_wr, four};
      typ   = 5'd0;
      if (kind == 7) begin
        if ($urandom_range(0, 1) == 1) fmt = 3'($urandom_range(4, 7));
        else typ = 5'($urandom_range(1, 31));
      end
      dacc_mode = $urandom_range(0, 2);
      cmd_delay = $urandom_range(0, 3);
      gap_pct   = ($urandom_range(0, 1) == 1) ? 30 : 0;
      b = {};
      b.push_back({fmt, typ, 14'h0, 10'(L)});
      b.push_back($urandom & 32'h000000FF);
      b.push_back($urandom);
      if (four) b.push_back($urandom);
      total = b.size();
      if (kind <= 2) begin
        if ($urandom_range(0, 4) == 0) total = nh + 1;
      end else if (kind <= 6) begin
        sub = $urandom_range(0, 5);
        if (sub == 0 && L > 1)  total = nh + $urandom_range(1, L - 1);
        else if (sub == 1)      total = nh + L + $urandom_range(1, 2);
        else                    total = nh + L;
      end else if (kind == 7) begin
        total = $urandom_range(1, 5);
      end else if (kind == 8) begin
        total = $urandom_range(1, nh - 1);
      end
      while (b.size() < total) b.push_back($urandom);
      while (b.size() > total) void'(b.pop_back());
      send_tlp(b);
    end
    wait_idle();
    dacc_mode = 0;
    repeat (4) @(negedge clk);
    check("err_count_final", err_count, (exp_drops > 255) ? 255 : exp_drops);
    check("drop_pulses_final", obs_drops, exp_drops);
    check("cmd_queue_empty", cmd_q.size(), 0);
    check("data_queue_empty", dat_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
